// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: shows N_DIGITS hex digits one slot at a time,
// with optional all-off guard gaps, leading-zero blanking and a frame-synchronous
// double-buffered value load.
module seven_seg_scanner #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [4*N_DIGITS-1:0] load_value,
  output logic                  load_ready,
  input  logic                  lzb_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int unsigned KW = $clog2(N_DIGITS);

  typedef enum logic {StShow, StGuard} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d, k_next;
  logic [31:0]           cnt_q, cnt_d;
  logic                  started_q;
  logic [4*N_DIGITS-1:0] disp_q, pend_q, pend_d, disp_eff;
  logic                  pend_valid_q, pend_valid_d;
  logic                  ready_q;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  tick_q;
  logic                  frame_start, apply, accept, lit, run;
  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b0111111;
      4'h1:    decode = 7'b0000110;
      4'h2:    decode = 7'b1011011;
      4'h3:    decode = 7'b1001111;
      4'h4:    decode = 7'b1100110;
      4'h5:    decode = 7'b1101101;
      4'h6:    decode = 7'b1111101;
      4'h7:    decode = 7'b0000111;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1101111;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b1111100;
      4'hC:    decode = 7'b0111001;
      4'hD:    decode = 7'b1011110;
      4'hE:    decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  assign k_next = (k_q == KW'(N_DIGITS - 1)) ? '0 : k_q + 1'b1;

  // Slot sequencing: SHOW for REFRESH_DIV cycles, then GUARD (if any), then next digit.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q + 32'd1;
    if (!started_q) begin
      // First edge after reset presents digit 0 without advancing.
      state_d = StShow;
      k_d     = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StShow: begin
          if (cnt_q == REFRESH_DIV - 1) begin
            cnt_d = '0;
            if (GUARD_CYCLES != 0) state_d = StGuard;
            else                   k_d = k_next;
          end
        end
        StGuard: begin
          if (cnt_q == GUARD_CYCLES - 1) begin
            cnt_d   = '0;
            state_d = StShow;
            k_d     = k_next;
          end
        end
        default: state_d = StShow;
      endcase
    end
  end

  // Load handshake, frame-boundary swap and registered output values for the next cycle.
  always_comb begin
    frame_start  = (state_d == StShow) && (k_d == '0) && (cnt_d == '0);
    apply        = frame_start && pend_valid_q;
    accept       = load_valid && ready_q;
    pend_valid_d = (pend_valid_q && !apply) || accept;
    pend_d       = accept ? load_value : pend_q;
    disp_eff     = apply ? pend_q : disp_q;

    // A digit blanks when it and every more significant nibble are zero.
    blank = '0;
    run   = lzb_en;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      run      = run && (disp_eff[4*i +: 4] == 4'h0);
      blank[i] = run;
    end

    nib   = disp_eff[4*int'(k_d) +: 4];
    lit   = (state_d == StShow) && !blank[k_d];
    seg_d = lit ? decode(nib) : 7'b0;
    an_d  = lit ? ~(N_DIGITS'(1) << k_d) : '1;
  end

  // State, buffers and outputs; reset forces outputs off immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StShow;
      k_q          <= '0;
      cnt_q        <= '0;
      started_q    <= 1'b0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      seg_q        <= '0;
      an_q         <= '1;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      started_q    <= 1'b1;
      disp_q       <= disp_eff;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ready_q      <= !pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= frame_start;
    end
  end

  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a frame-position reference model.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  localparam int SL = RD + GC;
  localparam int FR = ND * SL;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_value;
  logic        load_ready;
  logic        lzb_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_disp, m_pend;
  bit          m_pv;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_tick, e_ready;

  logic [6:0] dec_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  seven_seg_scanner #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_value(load_value),
    .load_ready(load_ready),
    .lzb_en    (lzb_en),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mdl_reset();
    m_t = -1; m_disp = '0; m_pend = '0; m_pv = 0;
    e_seg = '0; e_an = 4'hF; e_tick = 0; e_ready = 1;
  endtask

  // Apply inputs, take one clock edge, advance the model, settle 1 time unit.
  task automatic step(input bit lv, input logic [15:0] v, input bit lz);
    bit acc, lit;
    int p, slot;
    logic [15:0] sh;
    load_valid = lv; load_value = v; lzb_en = lz;
    @(posedge clk);
    if (rst) begin
      mdl_reset();
    end else begin
      acc = lv && !m_pv;
      m_t++;
      p = m_t % FR;
      if (p == 0 && m_pv) begin m_disp = m_pend; m_pv = 0; end
      if (acc) begin m_pend = v; m_pv = 1; end
      slot = p / SL;
      sh = m_disp >> (4 * slot);
      lit = ((p % SL) < RD) && !(lz && slot >= 1 && sh == 16'h0);
      e_seg = lit ? dec_tab[sh[3:0]] : 7'b0;
      e_an = lit ? ~(4'b0001 << slot) : 4'hF;
      e_tick = (p == 0);
      e_ready = !m_pv;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mdl_reset();
    step(0, 16'h0, 0);
    step(1, 16'hBEEF, 0);
    checks++;
    if ({seg, an, frame_tick, load_ready} !== {7'b0, 4'hF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: seg=%b an=%b tick=%b rdy=%b want 0000000 1111 0 1",
               seg, an, frame_tick, load_ready);
    end
    rst = 1'b0;
    step(0, 16'h0, 0);
    checks++;
    if ({seg, an, frame_tick} !== {7'b0111111, 4'b1110, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: seg=%b an=%b tick=%b want 0111111 1110 1", seg, an, frame_tick);
    end
  endtask

  task automatic test_free_run();
    int ticks = 0;
    for (int c = 0; c < 3 * FR; c++) begin
      step(0, 16'h0, 0);
      ticks += frame_tick;
      checks++;
      if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
        errors++;
        $display("FAIL free_run t=%0d: got %b %b %b %b want %b %b %b %b", m_t,
                 seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL an_onehot t=%0d: an=%b want at most one 0", m_t, an);
      end
    end
    checks++;
    if (ticks !== 3) begin
      errors++;
      $display("FAIL tick_count: got %0d want 3", ticks);
    end
  endtask

  task automatic test_load();
    for (int c = 0; c < FR && (m_t % FR) != 6; c++) step(0, 16'h0, 0);
    step(1, 16'h12AF, 0);
    step(0, 16'h0, 0);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_busy: rdy=%b want 0", load_ready);
    end
    for (int c = 0; c < 2 * FR + 5; c++) begin
      step(0, 16'h0, 0);
      checks++;
      if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
        errors++;
        $display("FAIL load t=%0d: got %b %b %b %b want %b %b %b %b", m_t,
                 seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
      end
    end
  endtask

  task automatic test_lzb();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    for (int j = 0; j < 2; j++) begin
      step(1, vals[j], 1);
      for (int c = 0; c < 2 * FR + 5; c++) begin
        step(0, 16'h0, 1);
        checks++;
        if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
          errors++;
          $display("FAIL lzb %h t=%0d: got %b %b %b %b want %b %b %b %b", vals[j], m_t,
                   seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 16'h5A5A, 0);
    step(1, 16'h3333, 0);
    for (int c = 0; c < 2 * FR + 5; c++) begin
      step(0, 16'h0, 0);
      checks++;
      if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
        errors++;
        $display("FAIL b2b t=%0d: got %b %b %b %b want %b %b %b %b", m_t,
                 seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
      end
    end
    // Offer a load on the edge that starts a new frame.
    for (int c = 0; c < FR && (m_t % FR) != FR - 1; c++) step(0, 16'h0, 0);
    step(1, 16'h9C4E, 0);
    for (int c = 0; c < 2 * FR + 5; c++) begin
      step(0, 16'h0, 0);
      checks++;
      if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
        errors++;
        $display("FAIL boundary_load t=%0d: got %b %b %b %b want %b %b %b %b", m_t,
                 seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(7) == 0), 16'($urandom), ($urandom_range(3) != 0));
      checks++;
      if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
        errors++;
        $display("FAIL random t=%0d: got %b %b %b %b want %b %b %b %b", m_t,
                 seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < FR && (m_t % FR) != 7; c++) step(0, 16'h0, 0);
    step(1, 16'h7777, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({seg, an, frame_tick, load_ready} !== {7'b0, 4'hF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: seg=%b an=%b tick=%b rdy=%b want 0000000 1111 0 1",
               seg, an, frame_tick, load_ready);
    end
    mdl_reset();
    step(0, 16'h0, 0);
    rst = 1'b0;
    for (int c = 0; c < 2 * FR; c++) begin
      step(0, 16'h0, 0);
      checks++;
      if ({seg, an, frame_tick, load_ready} !== {e_seg, e_an, e_tick, e_ready}) begin
        errors++;
        $display("FAIL reset_mid t=%0d: got %b %b %b %b want %b %b %b %b", m_t,
                 seg, an, frame_tick, load_ready, e_seg, e_an, e_tick, e_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_value = '0; lzb_en = 1'b0;
    test_reset();
    test_free_run();
    test_load();
    test_lzb();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit per slot (legal >=1).
REQ-003 SHALL have parameter GUARD_CYCLES, default 16, all-off cycles between slots, for anti-ghosting (legal >=0).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  new display value offered.
REQ-007 SHALL have port load_value  input  4*N_DIGITS  hex nibbles; nibble i drives digit i, digit 0 = least significant.
REQ-008 SHALL have port load_ready  output  1  block can accept a value.
REQ-009 SHALL have port lzb_en  input  1  leading-zero blanking enable, sampled every cycle.
REQ-010 SHALL have port seg  output  7  segments, bit0=a..bit6=g, active-high.
REQ-011 SHALL have port an  output  N_DIGITS  digit enables, active-low, at most one bit low.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL decode nibbles 0..F to 0111111,0000110,1011011,1001111,1100110,1101101,1111101,0000111,1111111,1101111,1110111,1111100,0111001,1011110,1111001,1110001 (g..a).
REQ-014 SHALL implement FSM states SHOW and GUARD, a slot counter and a digit index k (0..N_DIGITS-1).
REQ-015 SHOW SHALL last exactly REFRESH_DIV cycles with an[k]=0, all other bits 1, seg=decode(display nibble k).
REQ-016 GUARD SHALL last exactly GUARD_CYCLES cycles with an all 1s and seg=0; if GUARD_CYCLES=0, GUARD SHALL be skipped.
REQ-017 After SHOW (or GUARD) for digit k, SHALL enter SHOW for k+1; after digit N_DIGITS-1, SHALL wrap to digit 0 (frame boundary).
REQ-018 seg, an and frame_tick SHALL be registered and change on the same edge as the FSM state; no combinational path from inputs to them.
REQ-019 Frame period SHALL be N_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles.
REQ-020 SHALL hold a display register and a one-entry pending buffer; load_ready SHALL equal NOT pending_valid, registered.
REQ-021 A load SHALL be accepted only on a cycle with load_valid=1 and load_ready=1; the value goes to pending and load_ready SHALL be 0 from the next cycle.
REQ-022 load_valid while load_ready=0 SHALL be ignored; no value lost or overwritten in pending.
REQ-023 At the frame-boundary edge, if pending_valid=1, display register SHALL take pending, pending SHALL clear, load_ready SHALL return to 1 next cycle.
REQ-024 A load accepted on the boundary cycle itself SHALL be applied at the following boundary, not the current one.
REQ-025 The display register SHALL never change mid-frame (no tearing).
REQ-026 frame_tick SHALL be 1 for exactly the first cycle of digit 0 SHOW in each frame, including the first frame after reset.
REQ-027 With lzb_en=1, digit i (i>=1) SHALL be blanked when nibbles N_DIGITS-1..i of the display register are all zero; digit 0 SHALL never be blanked.
REQ-028 A blanked digit SHALL keep its slot timing with an all 1s and seg=0.

Reset
REQ-029 While rst=1, SHALL immediately force seg=0, an=all 1s, frame_tick=0, load_ready=1, display register=0, pending cleared, state SHOW, k=0, counter 0.
REQ-030 Reset assertion mid-frame or mid-handshake SHALL discard pending data; first cycle after release SHALL be digit 0 SHOW with frame_tick=1.

Verification (N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1)
REQ-031 Reset then release -> during reset seg=0000000, an=1111, load_ready=1; first cycle after release an=1110, seg=0111111, frame_tick=1.
REQ-032 Load 16'h12AF when ready -> load_ready=0 next cycle, digits unchanged until next frame_tick; then digit0 seg=1110001, digit1 1110111, digit2 1011011, digit3 0000110; load_ready=1.
REQ-033 Free run -> each slot 4 cycles lit, 1 cycle an=1111/seg=0; frame_tick every 20 cycles; an never has two 0 bits.
REQ-034 lzb_en=1, value 16'h0050 -> digit3, digit2 slots an=1111; digit1 seg=1101101; digit0 seg=0111111; value 16'h0000 -> only digit0 lit.
REQ-035 Second load 16'h3333 while load_ready=0 -> ignored; display shows first value; load on boundary cycle appears one frame later.
REQ-036 rst pulsed mid-slot with pending loaded -> outputs reset asynchronously, pending discarded, display 0 after release.
